// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR address controller: state encoding,
// default sample-address width and memory read latency.
package fir_ctrl_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int MEM_LAT    = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MAC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/fir_addr_cnt.sv
// Current-sample address register: loadable, incrementing, wraps
// modulo 2^ADDR_W.
module fir_addr_cnt
   import fir_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] cnt
);

   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (inc) begin
         cnt_d = cnt_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fir_addr_ctrl.sv
// FIR filter address/control sequencer: per output sample walks TAPS
// sample/coefficient address pairs and then writes the accumulator out.
module fir_addr_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int TAPS   = 64,
   parameter int CW     = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_samples,
   output logic [ADDR_W-1:0] smp_addr,
   output logic [CW-1:0]     coef_addr,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              out_wr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done
);

   state_t              state_q, state_d;
   logic [CW-1:0]       k_q, k_d, k_next;
   logic [ADDR_W-1:0]   rem_q, rem_d;
   logic [ADDR_W-1:0]   smp_addr_q, smp_addr_d;
   logic [CW-1:0]       coef_addr_q, coef_addr_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [MEM_LAT-1:0]  vld_pipe_q, vld_pipe_d;
   logic [ADDR_W-1:0]   cur;
   logic                cur_load;
   logic                cur_inc;

   fir_addr_cnt #(
      .ADDR_W (ADDR_W)
   ) u_cur (
      .clk      (clk),
      .rst      (rst),
      .load     (cur_load),
      .inc      (cur_inc),
      .load_val (base_addr),
      .cnt      (cur)
   );

   // Address registers are loaded one state ahead so that the address for
   // tap k is on the outputs during the MAC cycle where k_q == k.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      rem_d       = rem_q;
      smp_addr_d  = smp_addr_q;
      coef_addr_d = coef_addr_q;
      out_addr_d  = out_addr_q;
      cur_load    = 1'b0;
      cur_inc     = 1'b0;
      k_next      = k_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cur_load = 1'b1;
               rem_d    = num_samples;
               state_d  = (num_samples == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            k_d         = '0;
            smp_addr_d  = cur;
            coef_addr_d = '0;
            state_d     = ST_MAC;
         end
         ST_MAC: begin
            k_d = k_next;
            if (k_q == CW'(TAPS - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               smp_addr_d  = cur - ADDR_W'(k_next);
               coef_addr_d = k_next;
            end
         end
         ST_DRAIN: begin
            out_addr_d = cur;
            state_d    = ST_WRITE;
         end
         ST_WRITE: begin
            cur_inc = 1'b1;
            rem_d   = rem_q - ADDR_W'(1);
            state_d = (rem_q == ADDR_W'(1)) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Address-valid flag delayed by the memory read latency becomes acc_en.
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      vld_pipe_d[0] = (state_q == ST_MAC);
      for (int i = 1; i < MEM_LAT; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         rem_q       <= '0;
         smp_addr_q  <= '0;
         coef_addr_q <= '0;
         out_addr_q  <= '0;
         vld_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         rem_q       <= rem_d;
         smp_addr_q  <= smp_addr_d;
         coef_addr_q <= coef_addr_d;
         out_addr_q  <= out_addr_d;
         vld_pipe_q  <= vld_pipe_d;
      end
   end

   assign smp_addr  = smp_addr_q;
   assign coef_addr = coef_addr_q;
   assign out_addr  = out_addr_q;
   assign acc_en    = vld_pipe_q[MEM_LAT-1];
   assign acc_clr   = (state_q == ST_LOAD);
   assign out_wr    = (state_q == ST_WRITE);
   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_MAC) ||
                      (state_q == ST_DRAIN) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_fir_addr_ctrl.sv
// Self-checking bench for fir_addr_ctrl (TAPS=4): per-cycle comparison of all
// outputs against a timeline model derived from the per-sample schedule.
module tb_fir_addr_ctrl;

   localparam int AW  = 13;
   localparam int T   = 4;
   localparam int CWT = 2;
   localparam int P   = T + 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [AW-1:0]  num_samples = '0;
   logic [AW-1:0]  smp_addr;
   logic [CWT-1:0] coef_addr;
   logic           acc_clr;
   logic           acc_en;
   logic           out_wr;
   logic [AW-1:0]  out_addr;
   logic           busy;
   logic           done;

   // Expected "last used" address values (outputs hold between uses).
   logic [AW-1:0]  exp_smp = '0;
   logic [CWT-1:0] exp_coef = '0;
   logic [AW-1:0]  exp_out = '0;

   int n_checks = 0;
   int n_pass   = 0;

   fir_addr_ctrl #(
      .ADDR_W (AW),
      .TAPS   (T),
      .CW     (CWT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .num_samples (num_samples),
      .smp_addr    (smp_addr),
      .coef_addr   (coef_addr),
      .acc_clr     (acc_clr),
      .acc_en      (acc_en),
      .out_wr      (out_wr),
      .out_addr    (out_addr),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Pulse start at the current negedge and check every cycle of the run plus
   // one idle cycle. Stops early (start low) after cycle abort_at if >= 0.
   task automatic drive_and_check_run(input string name, input int base, input int n,
                                      input bit noise, input int abort_at);
      int d = n * P;
      int cnt_wr = 0;
      int cnt_en = 0;
      logic [32:0] got, exp;
      logic e_clr, e_en, e_wr, e_busy, e_done;
      int s, p;
      start       = 1'b1;
      base_addr   = AW'(base);
      num_samples = AW'(n);
      for (int c = 0; c <= d + 1; c++) begin
         @(negedge clk);
         s = c / P;
         p = c % P;
         e_clr  = (c < d) && (p == 0);
         e_en   = (c < d) && (p >= 2) && (p <= T + 1);
         e_wr   = (c < d) && (p == T + 2);
         e_busy = (c < d);
         e_done = (c == d);
         if ((c < d) && (p >= 1) && (p <= T)) begin
            exp_smp  = AW'(base + s - (p - 1));
            exp_coef = CWT'(p - 1);
         end
         if (e_wr) exp_out = AW'(base + s);
         exp = {e_clr, e_en, e_wr, e_busy, e_done, exp_smp, exp_coef, exp_out};
         got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
         if (out_wr) cnt_wr++;
         if (acc_en) cnt_en++;
         n_checks++;
         if (got !== exp)
            $display("FAIL %s cycle=%0d got=%h expected=%h (clr,en,wr,busy,done,smp,coef,out)",
                     name, c, got, exp);
         else
            n_pass++;
         if (c == abort_at) begin
            start = 1'b0;
            return;
         end
         if (noise && c <= d) begin
            start       = 1'($urandom % 2);
            base_addr   = AW'($urandom);
            num_samples = AW'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      n_checks++;
      if (cnt_wr !== n)
         $display("FAIL %s_out_wr_count got=%0d expected=%0d", name, cnt_wr, n);
      else
         n_pass++;
      n_checks++;
      if (cnt_en !== n * T)
         $display("FAIL %s_acc_en_count got=%0d expected=%0d", name, cnt_en, n * T);
      else
         n_pass++;
      $display("run %s base=%0d n=%0d noise=%0d wr=%0d en=%0d", name, base, n, noise, cnt_wr, cnt_en);
   endtask

   task automatic test_reset();
      logic [32:0] got;
      #3;
      got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
      n_checks++;
      if (got !== 33'd0) $display("FAIL reset_async got=%h expected=0", got);
      else n_pass++;
      repeat (2) @(negedge clk);
      got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
      n_checks++;
      if (got !== 33'd0) $display("FAIL reset_held got=%h expected=0", got);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
      n_checks++;
      if (got !== 33'd0) $display("FAIL reset_idle got=%h expected=0", got);
      else n_pass++;
      $display("reset checked got=%h", got);
   endtask

   task automatic test_single();
      drive_and_check_run("single", 100, 1, 1'b0, -1);
   endtask

   task automatic test_wrap_low();
      drive_and_check_run("wrap_low", 2, 1, 1'b0, -1);
   endtask

   task automatic test_wrap_high();
      drive_and_check_run("wrap_high", 8191, 2, 1'b0, -1);
   endtask

   task automatic test_zero();
      drive_and_check_run("zero", 1234, 0, 1'b0, -1);
   endtask

   task automatic test_ignore_start();
      drive_and_check_run("ignore_start", 500, 2, 1'b1, -1);
      drive_and_check_run("ignore_zero", 77, 0, 1'b1, -1);
   endtask

   task automatic test_reset_mid_run();
      logic [32:0] got;
      int wr_seen = 0;
      drive_and_check_run("mid_rst_pre", 300, 3, 1'b0, P + 2);
      #2 rst = 1'b1;
      #1;
      got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
      n_checks++;
      if (got !== 33'd0) $display("FAIL mid_rst_async got=%h expected=0", got);
      else n_pass++;
      exp_smp  = '0;
      exp_coef = '0;
      exp_out  = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 2 * P; c++) begin
         @(negedge clk);
         if (out_wr) wr_seen++;
         got = {acc_clr, acc_en, out_wr, busy, done, smp_addr, coef_addr, out_addr};
         n_checks++;
         if (got !== 33'd0) $display("FAIL mid_rst_quiet cycle=%0d got=%h expected=0", c, got);
         else n_pass++;
      end
      $display("mid-run reset: out_wr after reset=%0d", wr_seen);
      drive_and_check_run("after_rst", 4000, 2, 1'b0, -1);
   endtask

   task automatic test_random();
      int base, n;
      for (int i = 0; i < 10; i++) begin
         case ($urandom % 4)
            0:       base = $urandom_range(0, T);
            1:       base = $urandom_range(8191 - 3, 8191);
            default: base = $urandom_range(0, 8191);
         endcase
         n = $urandom_range(0, 5);
         drive_and_check_run($sformatf("rand%0d", i), base, n, 1'($urandom % 2), -1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_low();
      test_wrap_high();
      test_zero();
      test_ignore_start();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_addr_ctrl.md
FIR_ADDR_CTRL -- requirements
Module: fir_addr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, width of sample-memory address.
REQ-002 SHALL have parameter TAPS, default 64, number of filter taps (power of two, 2..256).
REQ-003 SHALL have parameter CW, default clog2(TAPS), width of coefficient address.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse starting a filter run.
REQ-007 SHALL have port base_addr  in  ADDR_W  address of first output sample, captured at start.
REQ-008 SHALL have port num_samples  in  ADDR_W  output samples to compute, captured at start.
REQ-009 SHALL have port smp_addr  out  ADDR_W  sample-memory read address.
REQ-010 SHALL have port coef_addr  out  CW  coefficient-ROM read address.
REQ-011 SHALL have port acc_clr  out  1  clear accumulator.
REQ-012 SHALL have port acc_en  out  1  accumulate product of current memory outputs.
REQ-013 SHALL have port out_wr  out  1  write accumulator result to output memory.
REQ-014 SHALL have port out_addr  out  ADDR_W  output-memory write address.
REQ-015 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-016 SHALL have port done  out  1  one-cycle pulse after the last out_wr.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, MAC, DRAIN, WRITE, DONE.
REQ-018 IDLE: start=1 -> LOAD; capture base_addr into current-sample register cur, num_samples into remaining count rem.
REQ-019 IDLE with start=1 and num_samples=0 -> DONE directly; no acc_clr, acc_en, or out_wr issued.
REQ-020 LOAD: assert acc_clr for exactly one cycle; set tap index k=0; -> MAC.
REQ-021 MAC: each cycle drive smp_addr = (cur - k) mod 2^ADDR_W, coef_addr = k; increment k; after k=TAPS-1 -> DRAIN.
REQ-022 Memories have fixed 1-cycle read latency; acc_en SHALL be the MAC-state address-valid flag delayed one cycle, giving exactly TAPS acc_en cycles per sample.
REQ-023 DRAIN: one cycle for the final acc_en; -> WRITE.
REQ-024 WRITE: assert out_wr for one cycle with out_addr = cur; cur <= cur+1 mod 2^ADDR_W; rem <= rem-1; rem=1 -> DONE, else -> LOAD.
REQ-025 Per-sample period SHALL be TAPS+3 cycles (LOAD + TAPS MAC + DRAIN + WRITE).
REQ-026 Sample-address underflow (cur < k) SHALL wrap modulo 2^ADDR_W; no saturation.
REQ-027 cur increment at 2^ADDR_W-1 SHALL wrap to 0.
REQ-028 DONE: assert done one cycle, busy low; -> IDLE.
REQ-029 start while busy SHALL be ignored; base_addr and num_samples changes while busy SHALL have no effect.
REQ-030 start in the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-031 Outputs smp_addr, coef_addr, out_addr SHALL hold their last values when not in use.

Reset
REQ-032 rst SHALL force IDLE immediately, independent of clk.
REQ-033 On reset, smp_addr, out_addr, cur, rem = 0; coef_addr, k = 0; acc_clr, acc_en, out_wr, busy, done = 0.
REQ-034 Reset mid-run SHALL abort without issuing any further out_wr; the next start SHALL begin a fresh run.

Structure
REQ-035 A shared package fir_ctrl_pkg SHALL hold the FSM state encoding, ADDR_W default, and the memory-latency constant (1).
REQ-036 The current-sample register with load and increment SHALL be a sub-module fir_addr_cnt (ADDR_W wide, load enable, increment enable, async reset).
REQ-037 Tap counter, remaining counter, and acc_en delay stage SHALL stay in fir_addr_ctrl.

Verification
REQ-038 Reset then start with base_addr=100, num_samples=1, TAPS=4 -> smp_addr 100,99,98,97; coef_addr 0..3; 4 acc_en; one out_wr at out_addr=100; done 7 cycles after LOAD entry.
REQ-039 start with base_addr=2, TAPS=4 -> smp_addr 2,1,0,8191 (wrap).
REQ-040 start with base_addr=8191, num_samples=2 -> out_wr at 8191 then 0; exactly two out_wr; single done pulse.
REQ-041 start with num_samples=0 -> done next cycle; no acc_clr, acc_en, or out_wr.
REQ-042 Second start pulse mid-MAC with different base_addr -> ignored; output addresses follow the first base_addr.
REQ-043 rst asserted during MAC of sample 2 of 3 -> all outputs 0 at once; no further out_wr; a new start runs normally.
